// File: rtl/seg595_pkg.sv
// seg595_pkg: shared constants for the 74HC595 display-stream capture block.
//   - word geometry (14-bit {seg, sel} word, 8 segment bits, 6 digits)
//   - the 16 standard active-low hex glyphs as seg[6:0], indexed by value
//   - blank digit pattern
package seg595_pkg;

  localparam int SEG595_WORD_BITS = 14;
  localparam int SEG595_SEG_W     = 8;
  localparam int SEG595_DIGITS    = 6;

  localparam logic [7:0] SEG595_BLANK = 8'hFF;

  // Element i is the glyph for hex value i (g..a, active-low).
  localparam logic [15:0][6:0] SEG595_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational active-low seven-segment glyph to hex.
//   seg [7:0] in  : segment byte; seg[7] (dp) is ignored
//   hex [3:0] out : decoded value, 0 when the glyph is not recognised
//   ok        out : 1 only for one of the 16 standard glyphs
module seg7_glyph_decode
  import seg595_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] hex,
  output logic       ok
);

  logic unused_dp;
  assign unused_dp = seg[7];

  always_comb begin
    hex = '0;
    ok  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg[6:0] == SEG595_GLYPHS[i]) begin
        hex = 4'(i);
        ok  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_595_capture.sv
// seg_595_capture: oversampling receiver for the 74HC595 display stream.
//   Rebuilds each latched {seg, sel} word from ds/shcp/stcp, keeps a
//   per-digit frame buffer, and flags length / select errors.
// Ports:
//   sys_clk, sys_rst_n (async, active-low)
//   shcp, stcp, ds, oe : raw pins, sampled only (never used as clocks)
//   sel, seg, word_valid : last latched word + one-cycle strobe
//   frame, frame_valid   : digit buffer (digit i at [8i+7:8i]) + full-refresh strobe
//   disp_on              : synchronized ~oe
//   len_err, sel_err     : sticky errors, cleared by err_clr
//   hex, hex_ok          : per-digit glyph decode
// Optional: define SEG595_CAP_DECODE_EN to build the glyph decoders;
// otherwise hex/hex_ok are tied to 0.
module seg_595_capture
  import seg595_pkg::*;
#(
  parameter int DIGITS      = SEG595_DIGITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  shcp,
  input  logic                  stcp,
  input  logic                  ds,
  input  logic                  oe,
  input  logic                  err_clr,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  word_valid,
  output logic [8*DIGITS-1:0]   frame,
  output logic                  frame_valid,
  output logic                  disp_on,
  output logic                  len_err,
  output logic                  sel_err,
  output logic [4*DIGITS-1:0]   hex,
  output logic [DIGITS-1:0]     hex_ok
);

  localparam int W  = DIGITS + SEG595_SEG_W;
  localparam int CW = $clog2(W + 2);  // room to saturate above W

  // Synchronizers. The oe chain carries ~oe so every flop resets to 0
  // and disp_on still comes out of reset low.
  logic [SYNC_STAGES-1:0] shcp_q, stcp_q, ds_q, oen_q;
  logic                   shcp_d, stcp_d;

  logic [W-1:0]              sr, sr_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [DIGITS-1:0]         seen, lat_sel;
  logic [7:0]                lat_seg;
  logic [DIGITS-1:0][7:0]    frame_q;
  logic                      shcp_rise, stcp_rise, ds_s, sel_ok, seen_full;

  assign shcp_rise = shcp_q[SYNC_STAGES-1] & ~shcp_d;
  assign stcp_rise = stcp_q[SYNC_STAGES-1] & ~stcp_d;
  assign ds_s      = ds_q[SYNC_STAGES-1];
  assign disp_on   = oen_q[SYNC_STAGES-1];
  assign frame     = frame_q;
  assign seen_full = &seen;

  // Shift first; a latch in the same cycle sees the post-shift word.
  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = cnt;
    if (shcp_rise) begin
      sr_nxt = {ds_s, sr[W-1:1]};
      if (cnt != '1) cnt_nxt = cnt + 1'b1;
    end
    lat_sel = sr_nxt[DIGITS-1:0];
    lat_seg = '0;
    // First-shifted seg bit lands at seg[7].
    for (int k = 0; k < SEG595_SEG_W; k++) lat_seg[7-k] = sr_nxt[DIGITS+k];
    sel_ok = $onehot(lat_sel);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shcp_q      <= '0;
      stcp_q      <= '0;
      ds_q        <= '0;
      oen_q       <= '0;
      shcp_d      <= 1'b0;
      stcp_d      <= 1'b0;
      sr          <= '0;
      cnt         <= '0;
      sel         <= '0;
      seg         <= SEG595_BLANK;
      word_valid  <= 1'b0;
      frame_q     <= {DIGITS{SEG595_BLANK}};
      seen        <= '0;
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      shcp_q <= {shcp_q[SYNC_STAGES-2:0], shcp};
      stcp_q <= {stcp_q[SYNC_STAGES-2:0], stcp};
      ds_q   <= {ds_q[SYNC_STAGES-2:0], ds};
      oen_q  <= {oen_q[SYNC_STAGES-2:0], ~oe};
      shcp_d <= shcp_q[SYNC_STAGES-1];
      stcp_d <= stcp_q[SYNC_STAGES-1];

      sr          <= sr_nxt;
      cnt         <= stcp_rise ? '0 : cnt_nxt;
      word_valid  <= stcp_rise;
      frame_valid <= seen_full;

      // A full seen mask is reported next cycle and restarts collection;
      // a digit latched in that same cycle counts toward the next frame.
      seen <= (seen_full ? '0 : seen) | ((stcp_rise && sel_ok) ? lat_sel : '0);

      if (stcp_rise) begin
        sel <= lat_sel;
        seg <= lat_seg;
        if (sel_ok) begin
          for (int i = 0; i < DIGITS; i++)
            if (lat_sel[i]) frame_q[i] <= lat_seg;
        end
      end

      // Error event beats a simultaneous clear.
      if (stcp_rise && cnt_nxt != CW'(W)) len_err <= 1'b1;
      else if (err_clr)                   len_err <= 1'b0;

      if (stcp_rise && !sel_ok) sel_err <= 1'b1;
      else if (err_clr)         sel_err <= 1'b0;
    end
  end

`ifdef SEG595_CAP_DECODE_EN
  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    seg7_glyph_decode u_dec (
      .seg (frame_q[i]),
      .hex (hex[4*i +: 4]),
      .ok  (hex_ok[i])
    );
  end
`else
  assign hex    = '0;
  assign hex_ok = '0;
`endif

endmodule

// File: tb/tb_seg_595_capture.sv
// Directed bench for seg_595_capture: drives the pin protocol, keeps a
// small behavioural model of the receiver, and scoreboards every latched
// word against it.
module tb_seg_595_capture;

  logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic        shcp = 1'b0, stcp = 1'b0, ds = 1'b0, oe = 1'b1, err_clr = 1'b0;
  logic [5:0]  sel, hex_ok;
  logic [7:0]  seg;
  logic [47:0] frame;
  logic [23:0] hex;
  logic        word_valid, frame_valid, disp_on, len_err, sel_err;

  seg_595_capture #(.DIGITS(6), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .shcp(shcp), .stcp(stcp),
    .ds(ds), .oe(oe), .err_clr(err_clr), .sel(sel), .seg(seg),
    .word_valid(word_valid), .frame(frame), .frame_valid(frame_valid),
    .disp_on(disp_on), .len_err(len_err), .sel_err(sel_err),
    .hex(hex), .hex_ok(hex_ok)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, failures = 0;

  typedef struct {
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic [47:0] frame;
    logic        fv;
  } exp_t;
  exp_t q[$];

  // Reference model state
  logic [13:0]     m_sr;
  int              m_cnt;
  logic [5:0][7:0] m_frame;
  logic [5:0]      m_seen;
  logic            m_len, m_selerr;
  int              m_fv_cnt, fv_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic m_reset();
    m_sr = '0; m_cnt = 0; m_frame = {6{8'hFF}}; m_seen = '0;
    m_len = 1'b0; m_selerr = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    tick(3);
    shcp = 1'b1;
    m_sr = {b, m_sr[13:1]};
    if (m_cnt < 15) m_cnt++;
    tick(3);
    shcp = 1'b0;
    tick(3);
  endtask

  task automatic latch();
    exp_t e;
    logic [7:0] g;
    logic [5:0] s;
    stcp = 1'b1;
    s = m_sr[5:0];
    for (int k = 0; k < 8; k++) g[7-k] = m_sr[6+k];
    if (m_cnt != 14) m_len = 1'b1;
    m_cnt = 0;
    if ($onehot(s)) begin
      for (int i = 0; i < 6; i++) if (s[i]) m_frame[i] = g;
      m_seen = m_seen | s;
    end else m_selerr = 1'b1;
    e.sel = s; e.seg = g; e.frame = m_frame; e.fv = (m_seen == 6'h3F);
    if (e.fv) begin m_seen = '0; m_fv_cnt++; end
    q.push_back(e);
    tick(3);
    stcp = 1'b0;
    tick(4);
    chk("word_valid_timeout", 64'(q.size()), 0);
  endtask

  task automatic send_word(input logic [5:0] s, input logic [7:0] g, input int n);
    for (int k = 0; k < n; k++) shift_bit(k < 6 ? s[k] : g[13-k]);
    latch();
  endtask

  // Scoreboard: compare each latched word, then frame_valid one cycle later.
  always @(negedge sys_clk) begin
    if (sys_rst_n && word_valid) begin
      if (q.size() == 0) chk("word_valid_unexpected", 64'(word_valid), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sel", 64'(sel), 64'(e.sel));
        chk("seg", 64'(seg), 64'(e.seg));
        chk("frame_at_wv", 64'(frame), 64'(e.frame));
        @(negedge sys_clk);
        chk("frame_valid", 64'(frame_valid), 64'(e.fv));
      end
    end
  end

  always @(negedge sys_clk) if (sys_rst_n && frame_valid) fv_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset(); m_fv_cnt = 0; fv_cnt = 0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);

    // Reset state
    chk("rst_sel", 64'(sel), 0);
    chk("rst_seg", 64'(seg), 64'h FF);
    chk("rst_frame", 64'(frame), 64'hFFFF_FFFF_FFFF);
    chk("rst_wv", 64'(word_valid), 0);
    chk("rst_fv", 64'(frame_valid), 0);
    chk("rst_len_err", 64'(len_err), 0);
    chk("rst_sel_err", 64'(sel_err), 0);
    chk("rst_disp_on", 64'(disp_on), 0);
    chk("rst_hex", 64'(hex), 0);
    chk("rst_hex_ok", 64'(hex_ok), 0);

    // First word: digit 0 = "0"
    send_word(6'b000001, 8'hC0, 14);
    chk("w0_digit0", 64'(frame[7:0]), 64'hC0);
`ifdef SEG595_CAP_DECODE_EN
    chk("w0_hex0", 64'(hex[3:0]), 0);
    chk("w0_hex_ok0", 64'(hex_ok[0]), 1);
`else
    chk("w0_hex_off", 64'(hex), 0);
`endif

    // Scan glyphs 1..6 into digits 0..5
    send_word(6'b000001, 8'hF9, 14);
    send_word(6'b000010, 8'hA4, 14);
    send_word(6'b000100, 8'hB0, 14);
    send_word(6'b001000, 8'h99, 14);
    send_word(6'b010000, 8'h92, 14);
    send_word(6'b100000, 8'h82, 14);
    chk("scan_frame", 64'(frame), 64'h8292_99B0_A4F9);
    chk("scan_fv_count", 64'(fv_cnt), 1);
`ifdef SEG595_CAP_DECODE_EN
    chk("scan_hex", 64'(hex), 64'h654321);
    chk("scan_hex_ok", 64'(hex_ok), 64'h3F);
`endif

    // Short word -> len_err, clear, clean word keeps it clear
    send_word(6'b000010, 8'h88, 13);
    chk("short_len_err", 64'(len_err), 1);
    chk("short_sel_err", 64'(sel_err), 64'(m_selerr));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_len = 1'b0; m_selerr = 1'b0;
    tick(1);
    chk("clr_len_err", 64'(len_err), 0);
    chk("clr_sel_err", 64'(sel_err), 0);
    send_word(6'b000100, 8'hB0, 14);
    chk("clean_len_err", 64'(len_err), 0);

    // Non-one-hot select: flagged, frame untouched
    begin
      logic [47:0] f_before;
      f_before = m_frame;
      send_word(6'b000011, 8'h00, 14);
      chk("bad_sel_err", 64'(sel_err), 1);
      chk("bad_sel_frame", 64'(frame), 64'(f_before));
    end

    // Reset mid-word discards the partial word
    for (int k = 0; k < 7; k++) shift_bit(k[0]);
    sys_rst_n = 1'b0;
    tick(2);
    m_reset(); q.delete();
    sys_rst_n = 1'b1;
    tick(2);
    chk("mid_rst_sel_err", 64'(sel_err), 0);
    send_word(6'b100000, 8'h92, 14);
    chk("post_rst_sel", 64'(sel), 64'h20);
    chk("post_rst_seg", 64'(seg), 64'h92);
    chk("post_rst_len_err", 64'(len_err), 0);
    chk("post_rst_frame", 64'(frame), 64'h92FF_FFFF_FFFF);

    // oe -> disp_on latency
    chk("oe_high_disp", 64'(disp_on), 0);
    oe = 1'b0;
    tick(1);
    chk("oe_low_disp_1", 64'(disp_on), 0);
    tick(1);
    chk("oe_low_disp_2", 64'(disp_on), 1);

    tick(4);
    chk("fv_total", 64'(fv_cnt), 64'(m_fv_cnt));
    chk("sb_empty", 64'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
